sram_fifo_ctrl: RTL and testbench

//  Valid/ready FIFO controller that owns both ports of an external 1R1W pseudo-dual RAM
//  (registered ra/re/wa/we/wd inside the RAM; rd valid the cycle after re, 0 otherwise).

---
 rtl/sram_fifo_pkg.sv | 10 +
 rtl/sram_fifo_obuf.sv | 69 ++++++
 rtl/sram_fifo_ctrl.sv | 104 ++++++++++
 tb/tb_sram_fifo_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// rtl/sram_fifo_pkg.sv - shared types and constants for the SRAM-backed FIFO controller
package sram_fifo_pkg;
  typedef enum logic [1:0] {
    OBUF_EMPTY = 2'd0,
    OBUF_ONE   = 2'd1,
    OBUF_TWO   = 2'd2
  } obuf_state_e;

  localparam int OBUF_DEPTH = 2;
endpackage

// File: rtl/sram_fifo_obuf.sv
// rtl/sram_fifo_obuf.sv - 2-entry output buffer that absorbs RAM read returns
import sram_fifo_pkg::*;

module sram_fifo_obuf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             capture,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       obuf_cnt
);
  obuf_state_e      r_state;
  obuf_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_d0;
  logic [WIDTH-1:0] r_d1;
  logic             w_pop_fire;

  assign pop_valid  = (r_state != OBUF_EMPTY);
  assign pop_data   = r_d0;
  assign w_pop_fire = pop_valid & pop_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) r_state <= OBUF_EMPTY;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    obuf_cnt    = 2'd0;
    case (r_state)
      OBUF_EMPTY: begin
        if (capture) w_state_nxt = OBUF_ONE;
      end
      OBUF_ONE: begin
        obuf_cnt = 2'd1;
        if (capture && !w_pop_fire)      w_state_nxt = OBUF_TWO;
        else if (!capture && w_pop_fire) w_state_nxt = OBUF_EMPTY;
      end
      OBUF_TWO: begin
        obuf_cnt = 2'd2;
        if (w_pop_fire && !capture) w_state_nxt = OBUF_ONE;
      end
      default: w_state_nxt = OBUF_EMPTY;
    endcase
  end

  // r_d0 is always the head; a pop from TWO shifts the second entry forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d0 <= '0;
      r_d1 <= '0;
    end else begin
      case (r_state)
        OBUF_EMPTY: if (capture) r_d0 <= cap_data;
        OBUF_ONE: begin
          if (capture && w_pop_fire) r_d0 <= cap_data;
          else if (capture)          r_d1 <= cap_data;
        end
        OBUF_TWO: if (w_pop_fire) r_d0 <= r_d1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - FIFO controller driving an external 1R1W RAM with read prefetch
// Optional almost_full output enabled by defining SRAM_FIFO_AF_EN.
import sram_fifo_pkg::*;

module sram_fifo_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+2):0]     occupancy,
  output logic                         almost_full,
  output logic [$clog2(DEPTH)-1:0]     ram_ra,
  output logic                         ram_re,
  input  logic [WIDTH-1:0]             ram_rd,
  output logic [$clog2(DEPTH)-1:0]     ram_wa,
  output logic                         ram_we,
  output logic [WIDTH-1:0]             ram_wd
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(DEPTH + 2) + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_ram_cnt;
  logic          r_inflight;
  logic [CW-1:0] w_ram_cnt_nxt;
  logic [1:0]    w_obuf_cnt;
  logic [2:0]    w_pending;
  logic          w_push_fire;
  logic          w_pop_fire;
  logic          w_issue;

  assign push_ready  = (r_ram_cnt < CW'(DEPTH));
  assign w_push_fire = push_valid & push_ready & ~flush;
  assign w_pop_fire  = pop_valid & pop_ready;

  // Keep at most OBUF_DEPTH entries buffered or returning, counting this cycle's pop.
  assign w_pending = {1'b0, w_obuf_cnt} + {2'b0, r_inflight};
  assign w_issue   = (r_ram_cnt != '0) && !flush &&
                     (w_pending < (3'(OBUF_DEPTH) + {2'b0, w_pop_fire}));

  assign ram_we = w_push_fire;
  assign ram_wa = r_wr_ptr;
  assign ram_wd = w_push_fire ? push_data : '0;
  assign ram_re = w_issue;
  assign ram_ra = r_rd_ptr;

  assign w_ram_cnt_nxt = r_ram_cnt + CW'(w_push_fire) - CW'(w_issue);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ram_cnt  <= w_ram_cnt_nxt;
      r_inflight <= w_issue;
    end
  end

  sram_fifo_obuf #(.WIDTH(WIDTH)) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .capture   (r_inflight),
    .cap_data  (ram_rd),
    .pop_ready (pop_ready),
    .pop_valid (pop_valid),
    .pop_data  (pop_data),
    .obuf_cnt  (w_obuf_cnt)
  );

  assign occupancy = OW'(r_ram_cnt) + OW'(r_inflight) + OW'(w_obuf_cnt);

`ifdef SRAM_FIFO_AF_EN
  logic          r_almost_full;
  logic [OW-1:0] w_occ_nxt;

  assign w_occ_nxt = OW'(w_ram_cnt_nxt) + OW'(w_issue) + OW'(w_obuf_cnt)
                   + OW'(r_inflight) - OW'(w_pop_fire);

  always_ff @(posedge clk) begin
    if (rst || flush) r_almost_full <= 1'b0;
    else              r_almost_full <= (w_occ_nxt >= OW'(AF_THRESH));
  end

  assign almost_full = r_almost_full;
`else
  assign almost_full = 1'b0;
`endif
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - scoreboard bench for sram_fifo_ctrl with a behavioural RAM
module tb_sram_fifo_ctrl;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         push_valid = 1'b0;
  logic         push_ready;
  logic [W-1:0] push_data = '0;
  logic         pop_valid;
  logic         pop_ready = 1'b0;
  logic [W-1:0] pop_data;
  logic [4:0]   occupancy;
  logic         almost_full;
  logic [2:0]   ram_ra;
  logic         ram_re;
  logic [W-1:0] ram_rd;
  logic [2:0]   ram_wa;
  logic         ram_we;
  logic [W-1:0] ram_wd;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] mem [D];

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .occupancy(occupancy), .almost_full(almost_full),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_rd(ram_rd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_wd(ram_wd)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
    if (rst)         ram_rd <= '0;
    else if (ram_re) ram_rd <= mem[ram_ra];
    else             ram_rd <= '0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: the FIFO is just an ordered list of accepted-but-not-popped items.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("occupancy", 32'(occupancy), 32'(model_q.size()));
      if (model_q.size() == 0)      chk("pop_valid_empty", 32'(pop_valid), 0);
      if (model_q.size() >= D + 2)  chk("push_ready_full", 32'(push_ready), 0);
      if (model_q.size() < D)       chk("push_ready_room", 32'(push_ready), 1);
      if (dut.r_inflight)           chk("obuf_two_capture", 32'(dut.w_obuf_cnt == 2'd2), 0);
`ifdef SRAM_FIFO_AF_EN
      chk("almost_full", 32'(almost_full), 32'(model_q.size() >= AF));
`else
      chk("almost_full_tied", 32'(almost_full), 0);
`endif
      if (!flush) begin
        if (pop_valid && pop_ready) begin
          if (model_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_underflow actual=%0d required=none", pop_data);
          end else begin
            mon_exp = model_q.pop_front();
            chk("pop_data", 32'(pop_data), 32'(mon_exp));
          end
        end
        if (push_valid && push_ready) model_q.push_back(push_data);
      end else begin
        model_q.delete();
      end
    end else begin
      model_q.delete();
    end
  end

  task automatic push_one(input logic [W-1:0] d);
    push_valid = 1'b1;
    push_data  = d;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (push_ready) begin
        @(negedge clk);
        push_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL push_timeout actual=stalled required=accept");
    push_valid = 1'b0;
  endtask

  task automatic wait_pop(input string name, input logic [W-1:0] d);
    for (int k = 0; k < 10; k++) begin
      #1;
      if (pop_valid) begin
        chk(name, 32'(pop_data), 32'(d));
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL %s actual=no_pop required=%0d", name, d);
  endtask

  task automatic fill_ten();
    pop_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_one(8'(i));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_push_ready", 32'(push_ready), 1);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_ram_re", 32'(ram_re), 0);
    chk("rst_ram_we", 32'(ram_we), 0);

    // single item latency
    @(negedge clk);
    pop_ready  = 1'b1;
    push_valid = 1'b1;
    push_data  = 8'hA5;
    @(negedge clk);
    push_valid = 1'b0;
    #1 chk("single_ram_re", 32'(ram_re), 1);
    @(negedge clk);
    #1 chk("single_not_yet", 32'(pop_valid), 0);
    @(negedge clk);
    #1 chk("single_pop_valid", 32'(pop_valid), 1);
    chk("single_pop_data", 32'(pop_data), 32'h A5);
    @(negedge clk);
    #1 chk("single_occ_zero", 32'(occupancy), 0);

    // fill to DEPTH+2 then drain without bubbles
    @(negedge clk);
    fill_ten();
    #1;
    chk("fill_push_ready", 32'(push_ready), 0);
    chk("fill_occupancy", 32'(occupancy), 10);
    @(negedge clk);
    pop_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("drain_no_bubble", 32'(pop_valid), 1);
      chk("drain_order", 32'(pop_data), 32'(i));
      @(negedge clk);
    end
    #1 chk("drain_empty", 32'(occupancy), 0);

    // streaming
    @(negedge clk);
    pop_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      push_valid = 1'b1;
      push_data  = 8'(i);
      #1 chk("stream_push_ready", 32'(push_ready), 1);
      @(negedge clk);
    end
    push_valid = 1'b0;
    repeat (8) @(negedge clk);

    // random stalls
    for (int i = 0; i < 2000; i++) begin
      push_valid = 1'($urandom % 2);
      push_data  = 8'($urandom);
      pop_ready  = 1'($urandom % 2);
      @(negedge clk);
    end
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    repeat (20) @(negedge clk);
    #3 chk("random_drained", 32'(model_q.size()), 0);

    // flush with a full output buffer
    @(negedge clk);
    fill_ten();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_two_pop_valid", 32'(pop_valid), 0);
    chk("flush_two_occ", 32'(occupancy), 0);
    @(negedge clk);
    pop_ready = 1'b1;
    push_one(8'h3C);
    wait_pop("flush_two_fresh", 8'h3C);

    // flush with a read in flight
    @(negedge clk);
    fill_ten();
    pop_ready = 1'b1;
    @(negedge clk);
    pop_ready = 1'b0;
    #1 chk("flush_inflight_setup", 32'(dut.r_inflight), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_if_pop_valid", 32'(pop_valid), 0);
    chk("flush_if_occ", 32'(occupancy), 0);
    @(negedge clk);
    pop_ready = 1'b1;
    push_one(8'h3C);
    wait_pop("flush_if_fresh", 8'h3C);

    // same again with reset
    @(negedge clk);
    fill_ten();
    pop_ready = 1'b1;
    @(negedge clk);
    pop_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_pop_valid", 32'(pop_valid), 0);
    chk("rst_mid_occ", 32'(occupancy), 0);
    @(negedge clk);
    pop_ready = 1'b1;
    push_one(8'h3C);
    wait_pop("rst_mid_fresh", 8'h3C);

    repeat (3) @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
